// File: rtl/mgmt_bus_arbiter.sv
// Round-robin arbiter sharing the management register bus between NUM_MASTERS requesters.
// Each master owns a one-entry request buffer; reads hold the bus until completion or timeout.
module mgmt_bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MASTERS-1:0]      m_rd_en,
  input  logic [16*NUM_MASTERS-1:0]   m_rd_addr,
  input  logic [NUM_MASTERS-1:0]      m_wr_en,
  input  logic [16*NUM_MASTERS-1:0]   m_wr_addr,
  input  logic [8*NUM_MASTERS-1:0]    m_wr_data,
  output logic [NUM_MASTERS-1:0]      m_busy,
  output logic [NUM_MASTERS-1:0]      m_drop,
  output logic [NUM_MASTERS-1:0]      m_rd_valid,
  output logic [NUM_MASTERS-1:0]      m_rd_err,
  output logic [7:0]                  m_rd_data,
  output logic                        s_rd_en,
  output logic [15:0]                 s_rd_addr,
  input  logic                        s_rd_valid,
  input  logic [7:0]                  s_rd_data,
  output logic                        s_wr_en,
  output logic [15:0]                 s_wr_addr,
  output logic [7:0]                  s_wr_data
);

  localparam int unsigned N  = NUM_MASTERS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [N-1:0]    w_valid;
  logic [N-1:0]    w_is_rd;
  logic [N-1:0]    w_drop;
  logic [AW-1:0]   w_addr [N];
  logic [DW-1:0]   w_data [N];
  logic [N-1:0]    w_free;

  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_rd_valid;
  logic [N-1:0]    r_rd_err;
  logic [DW-1:0]   r_rd_data;
  logic            r_s_rd_en;
  logic [AW-1:0]   r_s_rd_addr;
  logic            r_s_wr_en;
  logic [AW-1:0]   r_s_wr_addr;
  logic [DW-1:0]   r_s_wr_data;

  logic            w_sel_found;
  logic [IW-1:0]   w_sel_idx;
  logic [IW:0]     w_sum;
  logic [IW:0]     w_inc;
  logic [IW-1:0]   w_rr_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_gnt_wr;
  logic            w_gnt_rd;
  logic            w_rd_done;
  logic            w_rd_to;

  // Per-master request buffer; an entry being released this edge can accept a new request.
  for (genvar g = 0; g < N; g++) begin : g_entry
    logic          w_rd;
    logic          w_wr;
    logic          w_open;
    logic          r_v;
    logic          r_rd;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic          r_drop;

    assign w_rd   = m_rd_en[g];
    assign w_wr   = m_wr_en[g];
    assign w_open = !r_v || w_free[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v    <= 1'b0;
        r_rd   <= 1'b0;
        r_a    <= '0;
        r_d    <= '0;
        r_drop <= 1'b0;
      end else begin
        r_drop <= ((w_rd || w_wr) && !w_open) || (w_rd && w_wr);
        if (w_free[g]) r_v <= 1'b0;
        if (w_open && (w_rd || w_wr)) begin
          r_v  <= 1'b1;
          r_rd <= w_rd;
          r_a  <= w_rd ? m_rd_addr[AW*g +: AW] : m_wr_addr[AW*g +: AW];
          r_d  <= m_wr_data[DW*g +: DW];
        end
      end
    end

    assign w_valid[g] = r_v;
    assign w_is_rd[g] = r_rd;
    assign w_addr[g]  = r_a;
    assign w_data[g]  = r_d;
    assign w_drop[g]  = r_drop;
  end

  // First full entry at or after the round-robin pointer, wrapping modulo N.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sum       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, r_rr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      if (!w_sel_found && w_valid[w_sum[IW-1:0]]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_sum[IW-1:0];
      end
    end
    w_inc = {1'b0, w_sel_idx} + (IW+1)'(1);
    if (w_inc >= (IW+1)'(N)) w_inc = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_cnt_nxt   = r_cnt;
    w_free      = '0;
    w_gnt_wr    = 1'b0;
    w_gnt_rd    = 1'b0;
    w_rd_done   = 1'b0;
    w_rd_to     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_rr_nxt = w_inc[IW-1:0];
          if (w_is_rd[w_sel_idx]) begin
            w_gnt_rd    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_RD_WAIT;
          end else begin
            w_gnt_wr           = 1'b1;
            w_free[w_sel_idx]  = 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        // A completion on the timeout edge takes priority over the abort.
        if (s_rd_valid) begin
          w_rd_done        = 1'b1;
          w_free[r_owner]  = 1'b1;
          w_cnt_nxt        = '0;
          w_state_nxt      = ST_IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_rd_to          = 1'b1;
          w_free[r_owner]  = 1'b1;
          w_cnt_nxt        = '0;
          w_state_nxt      = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr        <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_rd_valid  <= '0;
      r_rd_err    <= '0;
      r_rd_data   <= '0;
      r_s_rd_en   <= 1'b0;
      r_s_rd_addr <= '0;
      r_s_wr_en   <= 1'b0;
      r_s_wr_addr <= '0;
      r_s_wr_data <= '0;
    end else begin
      r_rr       <= w_rr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_s_wr_en  <= w_gnt_wr;
      r_s_rd_en  <= w_gnt_rd;
      r_rd_valid <= '0;
      r_rd_err   <= '0;
      if (w_gnt_wr) begin
        r_s_wr_addr <= w_addr[w_sel_idx];
        r_s_wr_data <= w_data[w_sel_idx];
      end
      if (w_gnt_rd) begin
        r_s_rd_addr <= w_addr[w_sel_idx];
        r_owner     <= w_sel_idx;
      end
      if (w_rd_done) begin
        r_rd_data           <= s_rd_data;
        r_rd_valid[r_owner] <= 1'b1;
      end else if (w_rd_to) begin
        r_rd_data           <= 8'hFF;
        r_rd_valid[r_owner] <= 1'b1;
        r_rd_err[r_owner]   <= 1'b1;
      end
    end
  end

  assign m_busy     = w_valid;
  assign m_drop     = w_drop;
  assign m_rd_valid = r_rd_valid;
  assign m_rd_err   = r_rd_err;
  assign m_rd_data  = r_rd_data;
  assign s_rd_en    = r_s_rd_en;
  assign s_rd_addr  = r_s_rd_addr;
  assign s_wr_en    = r_s_wr_en;
  assign s_wr_addr  = r_s_wr_addr;
  assign s_wr_data  = r_s_wr_data;

endmodule
